// File: rtl/ethernet_header_pkg.sv
// Shared Ethernet header definitions for the RX parser.
// Provides the ethernet_header struct (element [0] of every field is the
// first byte on the wire), header/length constants and the parser states.
package ethernet_header_pkg;

    typedef struct packed {
        logic [0:5][7:0] mac_destination;
        logic [0:5][7:0] mac_source;
        logic [0:1][7:0] eth_type_length;
    } ethernet_header;

    localparam logic [47:0] BROADCAST_MAC     = 48'hFF_FF_FF_FF_FF_FF;
    localparam int unsigned ETH_HDR_BYTES     = 14;
    localparam logic [15:0] ETH_MAX_LEN_FIELD = 16'd1500;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} eth_rx_state_t;

endpackage

// File: rtl/eth_header_parser_if.sv
// Byte-stream bundle around the Ethernet RX header parser.
//   rx_data/rx_valid/rx_sof/rx_eof : received byte stream (source -> parser)
//   header/hdr_valid               : captured header and its strobe
//   pl_data/pl_valid/pl_last       : forwarded payload bytes
//   frame_err/frame_drop           : per-frame status pulses
// master = stream source / sink side, slave = parser side.
interface eth_header_parser_if;
    import ethernet_header_pkg::*;

    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_sof;
    logic           rx_eof;
    ethernet_header header;
    logic           hdr_valid;
    logic [7:0]     pl_data;
    logic           pl_valid;
    logic           pl_last;
    logic           frame_err;
    logic           frame_drop;

    modport master (
        output rx_data, rx_valid, rx_sof, rx_eof,
        input  header, hdr_valid, pl_data, pl_valid, pl_last, frame_err, frame_drop
    );

    modport slave (
        input  rx_data, rx_valid, rx_sof, rx_eof,
        output header, hdr_valid, pl_data, pl_valid, pl_last, frame_err, frame_drop
    );

endinterface

// File: rtl/eth_mac_filter.sv
// Destination MAC filter (combinational).
//   dest   : the 6 destination bytes, dest[0] = first byte on the wire
//   accept : dest is OWN_MAC, or broadcast when ACCEPT_BROADCAST is set
module eth_mac_filter
    import ethernet_header_pkg::*;
#(
    parameter logic [47:0] OWN_MAC          = 48'h00_18_3E_01_EB_6E,
    parameter logic        ACCEPT_BROADCAST = 1'b1
) (
    input  logic [0:5][7:0] dest,
    output logic            accept
);

    assign accept = (dest == OWN_MAC) || (ACCEPT_BROADCAST && (dest == BROADCAST_MAC));

endmodule

// File: rtl/eth_header_parser.sv
// Ethernet RX header parser.
// Captures the 14-byte header from the RX byte stream, filters on the
// destination MAC and forwards the payload of accepted frames with one
// cycle of latency. The RX stream cannot stall, so there is no backpressure.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : eth_header_parser_if.slave (RX stream in; header, payload, status out)
// Build option: define ETH_LENGTH_CHECK_EN to compare the payload byte count
// against a type/length field of 1500 or less at end of frame.
//
// state   | meaning
// IDLE    | waiting for a start-of-frame byte
// HDR     | capturing header bytes 1..13
// PAYLOAD | forwarding payload of an accepted frame
// DROP    | discarding bytes until end of frame
module eth_header_parser
    import ethernet_header_pkg::*;
#(
    parameter logic [47:0] OWN_MAC           = 48'h00_18_3E_01_EB_6E,
    parameter logic        ACCEPT_BROADCAST  = 1'b1,
    parameter logic [15:0] MAX_PAYLOAD_BYTES = 16'd1500
) (
    input  logic               clk,
    input  logic               rst_n,
    eth_header_parser_if.slave bus
);

    localparam logic [3:0] HDR_LAST = 4'(ETH_HDR_BYTES - 1);

    eth_rx_state_t   state, state_n;
    logic [3:0]      hdr_cnt, hdr_cnt_n;
    logic [15:0]     pl_cnt, pl_cnt_n;
    logic [0:13][7:0] cap, cap_n;
    ethernet_header  header_q, header_n;
    logic            accept_q, accept_n, mac_ok;
    logic            hdr_valid_q, hdr_valid_n;
    logic [7:0]      pl_data_q, pl_data_n;
    logic            pl_valid_q, pl_valid_n;
    logic            pl_last_q, pl_last_n;
    logic            err_q, err_n;
    logic            drop_q, drop_n;
`ifdef ETH_LENGTH_CHECK_EN
    logic [15:0]     len_field;
    assign len_field = header_q.eth_type_length;
`endif

    eth_mac_filter #(
        .OWN_MAC          (OWN_MAC),
        .ACCEPT_BROADCAST (ACCEPT_BROADCAST)
    ) u_filter (
        .dest   (cap[0:5]),
        .accept (mac_ok)
    );

    // Header bytes are collected in cap and copied to the output header only
    // when an accepted header completes, so header stays stable between
    // hdr_valid pulses.
    always_comb begin
        state_n     = state;
        hdr_cnt_n   = hdr_cnt;
        pl_cnt_n    = pl_cnt;
        cap_n       = cap;
        header_n    = header_q;
        accept_n    = accept_q;
        hdr_valid_n = 1'b0;
        pl_data_n   = 8'h00;
        pl_valid_n  = 1'b0;
        pl_last_n   = 1'b0;
        err_n       = 1'b0;
        drop_n      = 1'b0;
        if (bus.rx_valid && bus.rx_sof) begin
            if (state == HDR) begin
                err_n = 1'b1;
            end
            if (state == PAYLOAD) begin
                // close the sink's open frame with an empty last byte
                err_n      = 1'b1;
                pl_valid_n = 1'b1;
                pl_last_n  = 1'b1;
            end
            cap_n     = '0;
            cap_n[0]  = bus.rx_data;
            hdr_cnt_n = 4'd1;
            pl_cnt_n  = '0;
            state_n   = HDR;
            if (bus.rx_eof) begin
                err_n     = 1'b1;
                hdr_cnt_n = '0;
                state_n   = IDLE;
            end
        end else if (bus.rx_valid) begin
            case (state)
                IDLE: ;
                HDR: begin
                    cap_n[hdr_cnt] = bus.rx_data;
                    hdr_cnt_n      = hdr_cnt + 4'd1;
                    if (hdr_cnt == 4'd6) begin
                        accept_n = mac_ok;
                    end
                    if (hdr_cnt == HDR_LAST) begin
                        hdr_cnt_n = '0;
                        if (accept_q) begin
                            hdr_valid_n = 1'b1;
                            header_n    = {cap[0:12], bus.rx_data};
                            state_n     = bus.rx_eof ? IDLE : PAYLOAD;
                        end else begin
                            drop_n  = 1'b1;
                            state_n = bus.rx_eof ? IDLE : DROP;
                        end
                    end else if (bus.rx_eof) begin
                        err_n     = 1'b1;
                        hdr_cnt_n = '0;
                        state_n   = IDLE;
                    end
                end
                PAYLOAD: begin
                    if (pl_cnt >= MAX_PAYLOAD_BYTES) begin
                        err_n      = 1'b1;
                        pl_valid_n = 1'b1;
                        pl_last_n  = 1'b1;
                        state_n    = bus.rx_eof ? IDLE : DROP;
                    end else begin
                        pl_cnt_n   = (pl_cnt == 16'hFFFF) ? pl_cnt : pl_cnt + 16'd1;
                        pl_data_n  = bus.rx_data;
                        pl_valid_n = 1'b1;
                        pl_last_n  = bus.rx_eof;
                        if (bus.rx_eof) begin
                            state_n = IDLE;
`ifdef ETH_LENGTH_CHECK_EN
                            if ((len_field <= ETH_MAX_LEN_FIELD) && (pl_cnt_n != len_field)) begin
                                err_n = 1'b1;
                            end
`endif
                        end
                    end
                end
                DROP: begin
                    if (bus.rx_eof) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            hdr_cnt     <= '0;
            pl_cnt      <= '0;
            cap         <= '0;
            header_q    <= '0;
            accept_q    <= 1'b0;
            hdr_valid_q <= 1'b0;
            pl_data_q   <= '0;
            pl_valid_q  <= 1'b0;
            pl_last_q   <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state       <= state_n;
            hdr_cnt     <= hdr_cnt_n;
            pl_cnt      <= pl_cnt_n;
            cap         <= cap_n;
            header_q    <= header_n;
            accept_q    <= accept_n;
            hdr_valid_q <= hdr_valid_n;
            pl_data_q   <= pl_data_n;
            pl_valid_q  <= pl_valid_n;
            pl_last_q   <= pl_last_n;
            err_q       <= err_n;
            drop_q      <= drop_n;
        end
    end

    assign bus.header     = header_q;
    assign bus.hdr_valid  = hdr_valid_q;
    assign bus.pl_data    = pl_data_q;
    assign bus.pl_valid   = pl_valid_q;
    assign bus.pl_last    = pl_last_q;
    assign bus.frame_err  = err_q;
    assign bus.frame_drop = drop_q;

endmodule

// File: tb/tb_eth_header_parser.sv
// Testbench for eth_header_parser: two instances (broadcast accepted /
// rejected) share one randomized RX stream; a frame-level reference model
// queues the expected events and a monitor checks them as they appear.
module tb_eth_header_parser;
    import ethernet_header_pkg::*;

    localparam logic [47:0] OWN   = 48'h00_18_3E_01_EB_6E;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam int          MAXPL = 1500;
    localparam int K_HDR = 0, K_PL = 1, K_ERR = 2, K_DROP = 3;

    typedef logic [7:0] byte_t;
    typedef struct {
        int             kind;
        ethernet_header hdr;
        byte_t          data;
        logic           last;
        bit             dc;
    } ev_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  rst_seen = 1'b0;
    byte_t rx_data = 8'h00;
    logic  rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_seen <= !rst_n;

    eth_header_parser_if bus0();
    eth_header_parser_if bus1();

    assign bus0.rx_data = rx_data;  assign bus1.rx_data = rx_data;
    assign bus0.rx_valid = rx_valid; assign bus1.rx_valid = rx_valid;
    assign bus0.rx_sof = rx_sof;    assign bus1.rx_sof = rx_sof;
    assign bus0.rx_eof = rx_eof;    assign bus1.rx_eof = rx_eof;

    eth_header_parser #(.OWN_MAC(OWN), .ACCEPT_BROADCAST(1'b1), .MAX_PAYLOAD_BYTES(16'd1500))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    eth_header_parser #(.OWN_MAC(OWN), .ACCEPT_BROADCAST(1'b0), .MAX_PAYLOAD_BYTES(16'd1500))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [1:0]     hv, plv, pll, fe, fd;
    byte_t          pld [2];
    ethernet_header hd  [2];
    assign hv[0] = bus0.hdr_valid;   assign hv[1] = bus1.hdr_valid;
    assign plv[0] = bus0.pl_valid;   assign plv[1] = bus1.pl_valid;
    assign pll[0] = bus0.pl_last;    assign pll[1] = bus1.pl_last;
    assign fe[0] = bus0.frame_err;   assign fe[1] = bus1.frame_err;
    assign fd[0] = bus0.frame_drop;  assign fd[1] = bus1.frame_drop;
    assign pld[0] = bus0.pl_data;    assign pld[1] = bus1.pl_data;
    assign hd[0] = bus0.header;      assign hd[1] = bus1.header;

    ev_t            expq [2][$];
    ethernet_header last_hdr [2];
    int             checks = 0;
    int             errors = 0;
    bit             end_chk = 1'b0;

    function automatic string kname(input int k);
        case (k)
            K_HDR:   return "hdr_valid";
            K_PL:    return "pl_valid";
            K_ERR:   return "frame_err";
            default: return "frame_drop";
        endcase
    endfunction

    task automatic push(input int g, input int kind, input ethernet_header h,
                        input byte_t d, input logic l, input bit dc);
        ev_t ev;
        ev.kind = kind; ev.hdr = h; ev.data = d; ev.last = l; ev.dc = dc;
        expq[g].push_back(ev);
    endtask

    // Frame-level reference: one call per sof-started segment. e = segment
    // ends with eof, otherwise it is cut by the next sof; cut = cut by reset.
    task automatic model(input byte_t b[$], input bit e, input bit cut);
        int          n, m;
        logic [47:0] dst;
        logic [111:0] hbits;
        bit          acc;
        n = b.size();
        for (int g = 0; g < 2; g++) begin
            if (n < 14) begin
                if (!cut) push(g, K_ERR, '0, 8'h00, 1'b0, 1'b1);
                continue;
            end
            dst = {b[0], b[1], b[2], b[3], b[4], b[5]};
            acc = (dst == OWN) || (g == 0 && dst == BCAST);
            if (!acc) begin
                push(g, K_DROP, '0, 8'h00, 1'b0, 1'b1);
                continue;
            end
            for (int i = 0; i < 14; i++) hbits[111-8*i -: 8] = b[i];
            push(g, K_HDR, hbits, 8'h00, 1'b0, 1'b1);
            m = n - 14;
            if (m > MAXPL) begin
                for (int i = 0; i < MAXPL; i++) push(g, K_PL, '0, b[14+i], 1'b0, 1'b0);
                push(g, K_PL, '0, 8'h00, 1'b1, 1'b1);
                push(g, K_ERR, '0, 8'h00, 1'b0, 1'b1);
                continue;
            end
            for (int i = 0; i < m; i++) push(g, K_PL, '0, b[14+i], e && (i == m - 1), 1'b0);
            if (cut) continue;
            if (!e) begin
                push(g, K_PL, '0, 8'h00, 1'b1, 1'b0);
                push(g, K_ERR, '0, 8'h00, 1'b0, 1'b1);
            end
`ifdef ETH_LENGTH_CHECK_EN
            else begin
                logic [15:0] len;
                len = {b[12], b[13]};
                if (m > 0 && len <= 16'd1500 && m != int'(len)) push(g, K_ERR, '0, 8'h00, 1'b0, 1'b1);
            end
`endif
        end
    endtask

    task automatic expect_ev(input int g, input int kind, input ethernet_header ah,
                             input byte_t ad, input logic al);
        ev_t ev;
        checks++;
        if (expq[g].size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s inst%0d: got pulse, required none", kname(kind), g);
        end else begin
            ev = expq[g].pop_front();
            if (ev.kind != kind) begin
                errors++;
                $display("FAIL event_order inst%0d: got %s, required %s", g, kname(kind), kname(ev.kind));
            end else if (kind == K_HDR && ah != ev.hdr) begin
                errors++;
                $display("FAIL header inst%0d: got %h, required %h", g, ah, ev.hdr);
            end else if (kind == K_PL && ((!ev.dc && ad != ev.data) || al != ev.last)) begin
                errors++;
                $display("FAIL payload inst%0d: got data=%h last=%b, required data=%h last=%b",
                         g, ad, al, ev.data, ev.last);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst_seen) begin
                checks++;
                if ({hv[g], plv[g], pll[g], fe[g], fd[g]} != 5'b0 || pld[g] != 8'h00 || hd[g] != '0) begin
                    errors++;
                    $display("FAIL reset_outputs inst%0d: got hv=%b plv=%b last=%b err=%b drop=%b data=%h hdr=%h, required all 0",
                             g, hv[g], plv[g], pll[g], fe[g], fd[g], pld[g], hd[g]);
                end
                last_hdr[g] = '0;
            end else begin
                if (hv[g]) begin
                    expect_ev(g, K_HDR, hd[g], 8'h00, 1'b0);
                    last_hdr[g] = hd[g];
                end else begin
                    checks++;
                    if (hd[g] != last_hdr[g]) begin
                        errors++;
                        $display("FAIL header_stable inst%0d: got %h, required %h", g, hd[g], last_hdr[g]);
                    end
                end
                if (plv[g]) expect_ev(g, K_PL, '0, pld[g], pll[g]);
                if (fe[g])  expect_ev(g, K_ERR, '0, 8'h00, 1'b0);
                if (fd[g])  expect_ev(g, K_DROP, '0, 8'h00, 1'b0);
            end
            if (end_chk) begin
                checks++;
                if (expq[g].size() != 0) begin
                    errors++;
                    $display("FAIL missing_events inst%0d: got %0d pending, required 0 (next %s)",
                             g, expq[g].size(), kname(expq[g][0].kind));
                end
            end
        end
    end

    int gap_pct = 0;

    task automatic idle(input int c);
        repeat (c) begin
            rx_valid = 1'b0;
            rx_sof   = 1'($urandom);
            rx_eof   = 1'($urandom);
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_byte(input byte_t d, input bit s, input bit e);
        rx_data = d; rx_valid = 1'b1; rx_sof = s; rx_eof = e;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    endtask

    task automatic send_seg(input byte_t b[$], input bit e);
        for (int i = 0; i < b.size(); i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
            drive_byte(b[i], i == 0, e && (i == b.size() - 1));
        end
    endtask

    task automatic mk_frame(output byte_t b[$], input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] tl, input int plen);
        b = {};
        for (int i = 0; i < 6; i++) b.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) b.push_back(src[47-8*i -: 8]);
        b.push_back(tl[15:8]);
        b.push_back(tl[7:0]);
        for (int i = 0; i < plen; i++) b.push_back(8'($urandom));
    endtask

    task automatic frame(input logic [47:0] dst, input int plen);
        byte_t fb[$];
        mk_frame(fb, dst, {16'($urandom), 32'($urandom)}, 16'(plen), plen);
        model(fb, 1'b1, 1'b0);
        send_seg(fb, 1'b1);
    endtask

    initial begin
        byte_t       fb[$];
        logic [47:0] dst, mask;
        logic [15:0] tl;
        int          plen, n, k;
        bit          e, prev_eof;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // unicast, fixed header and payload
        mk_frame(fb, OWN, 48'h11_22_33_44_55_66, 16'h0004, 0);
        fb.push_back(8'hDE); fb.push_back(8'hAD); fb.push_back(8'hBE); fb.push_back(8'hEF);
        model(fb, 1'b1, 1'b0); send_seg(fb, 1'b1);
        frame(BCAST, 4);
        frame(48'h02_00_00_00_00_01, 10);
        frame(OWN, 5);
        // runt ending on header byte 9, then 1-byte sof&eof runt
        mk_frame(fb, OWN, 48'hA1_A2_A3_A4_A5_A6, 16'h0800, 4);
        fb = fb[0:9];
        model(fb, 1'b1, 1'b0); send_seg(fb, 1'b1);
        fb = fb[0:0];
        model(fb, 1'b1, 1'b0); send_seg(fb, 1'b1);
        frame(OWN, 0);
        frame(OWN, 1503);
        frame(OWN, 1500);
        // sof injected at payload byte 3, with gaps
        gap_pct = 30;
        mk_frame(fb, OWN, 48'h10_20_30_40_50_60, 16'h0010, 10);
        fb = fb[0:16];
        model(fb, 1'b0, 1'b0); send_seg(fb, 1'b0);
        mk_frame(fb, OWN, 48'h66_55_44_33_22_11, 16'h0806, 6);
        model(fb, 1'b1, 1'b0); send_seg(fb, 1'b1);
        gap_pct = 0;
        // length field 8 with 6 payload bytes
        mk_frame(fb, OWN, 48'h01_02_03_04_05_06, 16'h0008, 6);
        model(fb, 1'b1, 1'b0); send_seg(fb, 1'b1);
        // reset mid-payload
        mk_frame(fb, OWN, 48'hC0_C1_C2_C3_C4_C5, 16'h0014, 20);
        fb = fb[0:18];
        model(fb, 1'b0, 1'b1); send_seg(fb, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        frame(OWN, 3);

        prev_eof = 1'b1;
        for (int f = 0; f < 120; f++) begin
            case ($urandom_range(0, 3))
                0, 1: dst = OWN;
                2:    dst = BCAST;
                default: begin
                    mask = 48'hFF;
                    mask = mask << (8 * $urandom_range(0, 5));
                    dst = OWN ^ mask;
                end
            endcase
            plen = $urandom_range(0, 40);
            tl = $urandom_range(0, 1) ? 16'(plen) : 16'($urandom);
            mk_frame(fb, dst, {16'($urandom), 32'($urandom)}, tl, plen);
            gap_pct = $urandom_range(0, 40);
            k = $urandom_range(0, 9);
            e = 1'b1;
            if (k == 0) begin
                n = prev_eof ? $urandom_range(1, 13) : $urandom_range(2, 13);
                fb = fb[0:n-1];
            end else if (k == 1) begin
                n = $urandom_range(1, fb.size());
                fb = fb[0:n-1];
                e = 1'b0;
            end
            model(fb, e, 1'b0);
            send_seg(fb, e);
            prev_eof = e;
            if (e && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) drive_byte(8'($urandom), 1'b0, 1'($urandom));
            end
        end
        gap_pct = 0;
        frame(OWN, 8);

        idle(20);
        end_chk = 1'b1;
        @(negedge clk); #1;
        end_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
